literal_sequencer: RTL

LITERAL_SEQUENCER -- requirements
Module: literal_sequencer

---
 rtl/aoc_bits_pkg.sv | 28 ++
 rtl/nibble_accumulator.sv | 56 +++++
 rtl/literal_sequencer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/aoc_bits_pkg.sv
// Shared types and sizing for the literal group decoder.
// The state encoding and literal geometry are common to all blocks.
package aoc_bits_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_DRAIN,
    ST_HOLD
  } state_t;

  localparam int LIT_MAX_NIBBLES = 16;
  localparam int LIT_GROUP_W     = 5;
  localparam int LIT_W           = 64;
  localparam int CNT_W           = 5;
  localparam int BITS_W          = 7;

  // Sum pinned at all-ones rather than wrapping.
  function automatic logic [BITS_W-1:0] sat_add(
    input logic [BITS_W-1:0] a,
    input logic [BITS_W-1:0] b
  );
    logic [BITS_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[BITS_W] ? {BITS_W{1'b1}} : s[BITS_W-1:0];
  endfunction

endpackage

// File: rtl/nibble_accumulator.sv
// Shift-in nibble register with a retained-nibble counter.
// Once MAX_NIBBLES are held, further shifts are ignored.
module nibble_accumulator
  import aoc_bits_pkg::*;
#(
  parameter int MAX_NIBBLES = LIT_MAX_NIBBLES
) (
  input  logic             clk,
  input  logic             resetB,
  input  logic             clr,
  input  logic             shift_en,
  input  logic [3:0]       nibble,
  output logic [LIT_W-1:0] acc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(MAX_NIBBLES);

  logic [LIT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_shift;

  assign do_shift = !clr && shift_en &&
                    (cnt_q != CNT_MAX);

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    unique case (1'b1)
      clr: begin
        acc_d = '0;
        cnt_d = '0;
      end
      do_shift: begin
        acc_d = {acc_q[LIT_W-5:0], nibble};
        cnt_d = cnt_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetB) begin
    if (!resetB) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign acc   = acc_q;
  assign count = cnt_q;

endmodule

// File: rtl/literal_sequencer.sv
// Decodes a run of 5-bit continuation groups into one literal,
// with overflow draining and a held result until accepted.
module literal_sequencer
  import aoc_bits_pkg::*;
#(
  parameter int MAX_NIBBLES = LIT_MAX_NIBBLES,
  parameter int GROUP_W     = LIT_GROUP_W
) (
  input  logic               clk,
  input  logic               resetB,
  input  logic               start,
  input  logic               grp_valid,
  input  logic [GROUP_W-1:0] grp_data,
  output logic               grp_ready,
  output logic               lit_valid,
  input  logic               lit_ready,
  output logic [LIT_W-1:0]   lit_value,
  output logic [CNT_W-1:0]   lit_nibbles,
  output logic               lit_overflow,
  output logic [BITS_W-1:0]  bits_consumed,
  output logic               busy
);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(MAX_NIBBLES - 1);
  localparam logic [BITS_W-1:0] GRP_BITS =
    BITS_W'(GROUP_W);

  state_t            state_q, state_d;
  logic              ovf_q, ovf_d;
  logic [BITS_W-1:0] bits_q, bits_d;
  logic              clr;
  logic              shift_en;
  logic              cont;
  logic [3:0]        nibble;
  logic [CNT_W-1:0]  count;

  assign cont   = grp_data[GROUP_W-1];
  assign nibble = grp_data[3:0];

  always_comb begin
    state_d   = state_q;
    ovf_d     = ovf_q;
    bits_d    = bits_q;
    clr       = 1'b0;
    shift_en  = 1'b0;
    grp_ready = 1'b0;
    lit_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          clr     = 1'b1;
          ovf_d   = 1'b0;
          bits_d  = '0;
          state_d = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        grp_ready = 1'b1;
        if (grp_valid) begin
          shift_en = 1'b1;
          bits_d   = sat_add(bits_q, GRP_BITS);
          if (!cont) begin
            state_d = ST_HOLD;
          end else if (count == CNT_LAST) begin
            ovf_d   = 1'b1;
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        grp_ready = 1'b1;
        if (grp_valid) begin
          bits_d = sat_add(bits_q, GRP_BITS);
          if (!cont) begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        lit_valid = 1'b1;
        // Back-to-back literal: accept and restart on one edge.
        if (lit_ready) begin
          if (start) begin
            clr     = 1'b1;
            ovf_d   = 1'b0;
            bits_d  = '0;
            state_d = ST_COLLECT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetB) begin
    if (!resetB) begin
      state_q <= ST_IDLE;
      ovf_q   <= 1'b0;
      bits_q  <= '0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
      bits_q  <= bits_d;
    end
  end

  nibble_accumulator #(
    .MAX_NIBBLES(MAX_NIBBLES)
  ) u_acc (
    .clk     (clk),
    .resetB  (resetB),
    .clr     (clr),
    .shift_en(shift_en),
    .nibble  (nibble),
    .acc     (lit_value),
    .count   (count)
  );

  assign lit_nibbles   = count;
  assign lit_overflow  = ovf_q;
  assign bits_consumed = bits_q;
  assign busy          = (state_q != ST_IDLE);

endmodule
